// File: rtl/bidir_shift_reg_if.sv
// Serial-in / parallel-out bus for bidir_shift_reg: serial bit, enable and
// direction toward the register, full register contents back.
interface bidir_shift_reg_if #(
  parameter int MSB = 16
);
  logic           d;
  logic           en;
  logic           dir;
  logic [MSB-1:0] out;

  modport master (output d, output en, output dir, input out);
  modport slave  (input d, input en, input dir, output out);
endinterface

// File: rtl/bidir_shift_reg.sv
// Bidirectional serial-in/parallel-out shift register. The rstn port is
// active-high despite its name. Bits shifted past either end are dropped.
module bidir_shift_reg #(
  parameter int MSB = 16
) (
  input  logic              clk,
  input  logic              rstn,
  bidir_shift_reg_if.slave  bus
);

  logic [MSB-1:0] r_shift;
  logic [MSB-1:0] w_next;

  always_comb begin
    w_next = r_shift;
    if (bus.en) begin
      if (bus.dir) w_next = {bus.d, r_shift[MSB-1:1]};
      else         w_next = {r_shift[MSB-2:0], bus.d};
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) r_shift <= '0;
    else      r_shift <= w_next;
  end

  assign bus.out = r_shift;

endmodule

// File: tb/tb_bidir_shift_reg.sv
// Self-checking bench for bidir_shift_reg (MSB=16): scripted vectors,
// a full-length traversal sequence and a randomised phase against a model.
module tb_bidir_shift_reg;

  localparam int W = 16;

  typedef struct {
    logic         rst;
    logic         en;
    logic         dir;
    logic         d;
    logic         chk;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  bidir_shift_reg_if #(.MSB(W)) bus ();

  bidir_shift_reg #(.MSB(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];
  string        sb_name[$];
  int unsigned  errors = 0;
  int unsigned  checks = 0;

  task automatic add(input logic rst, input logic en, input logic dir,
                     input logic d, input logic chk, input logic [W-1:0] exp,
                     input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.dir = dir; v.d = d;
    v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one edge; an expected value is queued at drive time and popped
  // once the DUT has registered that edge.
  task automatic step(input logic rst, input logic en, input logic dir,
                      input logic d, input logic chk, input logic [W-1:0] exp,
                      input string name);
    logic [W-1:0] e;
    string        n;
    rstn   = rst;
    bus.en = en;
    bus.dir = dir;
    bus.d  = d;
    if (chk) begin
      sb_q.push_back(exp);
      sb_name.push_back(name);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n = sb_name.pop_front();
      checks++;
      if (bus.out !== e) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h", n, bus.out, e);
      end
    end
  endtask

  task automatic shift_bits(input logic [15:0] pattern, input int unsigned nbits,
                            input logic dir);
    for (int i = int'(nbits) - 1; i >= 0; i--)
      add(1'b0, 1'b1, dir, pattern[i], 1'b0, '0, "load");
  endtask

  initial begin
    logic [W-1:0] model;
    logic         r_rst, r_en, r_dir, r_d;

    bus.d = 1'b0; bus.en = 1'b0; bus.dir = 1'b0;
    @(negedge clk);

    // Reset
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, "reset_edge1");
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, "reset_edge2");
    // Left shift
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, "left_1");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, "left_2");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, "left_3");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, "left_4");
    for (int unsigned i = 0; i < 15; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "flush");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "left_flush_msb");
    // Right shift
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_r");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, "right_1");
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4000, "right_2");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA000, "right_3");
    for (int unsigned i = 0; i < 15; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, "fill");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, "right_fill");
    // Direction change
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_dc");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, "dc_left1");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, "dc_left2");
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, "dc_right");
    // Enable hold
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "reset_eh");
    shift_bits(16'h00A5, 8, 1'b0);
    vecs[vecs.size()-1].chk = 1'b1;
    vecs[vecs.size()-1].exp = 16'h00A5;
    vecs[vecs.size()-1].name = "load_a5";
    for (int unsigned i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'(i % 2), 1'(~i[0]), 1'b1, 16'h00A5, "en_hold");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h014B, "en_resume");
    // Reset priority
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "reset_rp");
    shift_bits(16'h1234, 13, 1'b0);
    vecs[vecs.size()-1].chk = 1'b1;
    vecs[vecs.size()-1].exp = 16'h1234;
    vecs[vecs.size()-1].name = "load_1234";
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, "reset_prio");
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, "after_reset");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].d, vecs[i].chk,
           vecs[i].exp, vecs[i].name);

    // A single 1 shifted right travels from bit 15 to bit 0 in 16 edges
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_trav");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, "trav_start");
    for (int unsigned i = 1; i < 16; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8000 >> i, "trav_right");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, "trav_drop_lsb");

    // Randomised mix against a behavioural model
    model = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_rand");
    for (int unsigned i = 0; i < 300; i++) begin
      r_rst = ($urandom_range(0, 19) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_dir = 1'($urandom_range(0, 1));
      r_d   = 1'($urandom_range(0, 1));
      if (r_rst)      model = '0;
      else if (r_en)  model = r_dir ? {r_d, model[W-1:1]} : {model[W-2:0], r_d};
      step(r_rst, r_en, r_dir, r_d, 1'b1, model, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
